axi_lite_uart: RTL and testbench

- AXI4-Lite slave UART that sits directly downstream of the AXI4-to-Lite bridge in the peripheral wrapper, in place of the vendor 16550 core.
- Consumes the 13-bit-address, 32-bit-data lite channels the bridge produces.
- Drives the board serial pins and a level interrupt to the PLIC.
- Provides TX/RX FIFOs, a fixed-divisor baud generator and a 4-register map.

---
 rtl/axi_lite_uart.sv | 370 +++++++++++++++++++++++++++++++++++++
 tb/tb_axi_lite_uart.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_uart.sv
// AXI4-Lite UART with TX/RX FIFOs, fixed-divisor baud timing and a 4-register map.
// Define UART_PARITY_EN for 8E1 framing; the default build is 8N1.
module axi_lite_uart #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_aw_addr,
    input  logic                  s_aw_valid,
    output logic                  s_aw_ready,
    input  logic [31:0]           s_w_data,
    input  logic [3:0]            s_w_strb,
    input  logic                  s_w_valid,
    output logic                  s_w_ready,
    output logic [1:0]            s_b_resp,
    output logic                  s_b_valid,
    input  logic                  s_b_ready,
    input  logic [ADDR_WIDTH-1:0] s_ar_addr,
    input  logic                  s_ar_valid,
    output logic                  s_ar_ready,
    output logic [31:0]           s_r_data,
    output logic [1:0]            s_r_resp,
    output logic                  s_r_valid,
    input  logic                  s_r_ready,
    input  logic                  uart_RX,
    output logic                  uart_TX,
    output logic                  interrupt
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
    localparam logic [15:0] BitLast = 16'(CLK_DIV - 1);
    localparam logic [15:0] HalfBit = 16'(CLK_DIV / 2);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} uart_state_e;

    logic            aw_ready_q, w_ready_q, aw_full_q, w_full_q, b_valid_q;
    logic [1:0]      wr_addr_q;
    logic [7:0]      wr_data_q;
    logic            wr_strb_q;
    logic            r_valid_q;
    logic [31:0]     r_data_q, rdata;
    logic            intr_en_q, tx_flush_q, rx_flush_q, intr_q;
    logic            overrun_q, frame_err_q, parity_err;
    logic [7:0]      status;

    logic [7:0]      tx_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] tx_wptr_q, tx_rptr_q;
    logic [CntW-1:0] tx_cnt_q;
    logic [7:0]      rx_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] rx_wptr_q, rx_rptr_q;
    logic [CntW-1:0] rx_cnt_q;
    logic            tx_empty, tx_full, rx_empty, rx_full;

    uart_state_e     tx_state_q, rx_state_q;
    logic [15:0]     tx_baud_q, rx_baud_q;
    logic [2:0]      tx_bit_q, rx_bit_q;
    logic [7:0]      tx_shift_q, rx_shift_q;
    logic            tx_q;
    logic            rx_s1_q, rx_s2_q, rx_prev_q;

    logic wr_fire, ar_hs, tx_push, tx_pop, rx_push, rx_pop, ctrl_wr, stat_rd;
    logic rx_stop_hit, rx_frame_bad, rx_par_bad, rx_ovr;
    logic unused_bits;

`ifdef UART_PARITY_EN
    logic tx_par_q, rx_par_q, parity_err_q;
    assign parity_err = parity_err_q;
    assign rx_par_bad = rx_stop_hit && rx_s2_q && (rx_par_q != ^rx_shift_q);
`else
    assign parity_err = 1'b0;
    assign rx_par_bad = 1'b0;
`endif

    assign unused_bits = ^{s_aw_addr[ADDR_WIDTH-1:4], s_aw_addr[1:0], s_ar_addr[ADDR_WIDTH-1:4],
                           s_ar_addr[1:0], s_w_data[31:8], s_w_strb[3:1]};

    assign s_aw_ready = aw_ready_q;
    assign s_w_ready  = w_ready_q;
    assign s_b_valid  = b_valid_q;
    assign s_b_resp   = 2'b00;
    assign s_ar_ready = !r_valid_q;
    assign s_r_valid  = r_valid_q;
    assign s_r_data   = r_data_q;
    assign s_r_resp   = 2'b00;
    assign uart_TX    = tx_q;
    assign interrupt  = intr_q;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FullCnt);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FullCnt);

    // Register write fires once both address and data have been captured.
    assign wr_fire = aw_full_q && w_full_q;
    assign tx_push = wr_fire && wr_strb_q && (wr_addr_q == 2'd1) && !tx_full;
    assign ctrl_wr = wr_fire && wr_strb_q && (wr_addr_q == 2'd3);
    assign ar_hs   = s_ar_valid && !r_valid_q;
    assign rx_pop  = ar_hs && (s_ar_addr[3:2] == 2'd0) && !rx_empty;
    assign stat_rd = ar_hs && (s_ar_addr[3:2] == 2'd2);
    assign tx_pop  = (tx_state_q == StIdle) && !tx_empty;

    assign rx_stop_hit  = (rx_state_q == StStop) && (rx_baud_q == BitLast);
    assign rx_frame_bad = rx_stop_hit && !rx_s2_q;
    assign rx_ovr       = rx_stop_hit && rx_s2_q && !rx_par_bad && rx_full;
    assign rx_push      = rx_stop_hit && rx_s2_q && !rx_par_bad && !rx_full;

    assign status = {parity_err, frame_err_q, overrun_q, intr_en_q,
                     tx_full, tx_empty, rx_full, !rx_empty};

    always_comb begin
        rdata = 32'h0;
        case (s_ar_addr[3:2])
            2'd0:    rdata = rx_empty ? 32'h0 : {24'h0, rx_mem_q[rx_rptr_q]};
            2'd2:    rdata = {24'h0, status};
            default: rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            b_valid_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
        end else begin
            if (s_aw_valid && aw_ready_q) begin
                aw_ready_q <= 1'b0;
                aw_full_q  <= 1'b1;
                wr_addr_q  <= s_aw_addr[3:2];
            end
            if (s_w_valid && w_ready_q) begin
                w_ready_q <= 1'b0;
                w_full_q  <= 1'b1;
                wr_data_q <= s_w_data[7:0];
                wr_strb_q <= s_w_strb[0];
            end
            if (wr_fire) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
                b_valid_q <= 1'b1;
            end
            if (b_valid_q && s_b_ready) begin
                b_valid_q  <= 1'b0;
                aw_ready_q <= 1'b1;
                w_ready_q  <= 1'b1;
            end
            if (ar_hs) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rdata;
            end else if (r_valid_q && s_r_ready) begin
                r_valid_q <= 1'b0;
            end
        end
    end

    // Sticky error flags: a new error in the same cycle as a STATUS read is kept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            intr_en_q   <= 1'b0;
            tx_flush_q  <= 1'b0;
            rx_flush_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            intr_q      <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            tx_flush_q <= ctrl_wr && wr_data_q[0];
            rx_flush_q <= ctrl_wr && wr_data_q[1];
            if (ctrl_wr) intr_en_q <= wr_data_q[4];
            if (stat_rd) begin
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end
            if (rx_ovr) overrun_q <= 1'b1;
            if (rx_frame_bad) frame_err_q <= 1'b1;
`ifdef UART_PARITY_EN
            if (stat_rd) parity_err_q <= 1'b0;
            if (rx_par_bad) parity_err_q <= 1'b1;
`endif
            intr_q <= intr_en_q && (!rx_empty || tx_empty);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) tx_mem_q[i] <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else if (tx_flush_q) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else begin
            if (tx_push) begin
                tx_mem_q[tx_wptr_q] <= wr_data_q;
                tx_wptr_q           <= tx_wptr_q + PtrW'(1);
            end
            if (tx_pop) tx_rptr_q <= tx_rptr_q + PtrW'(1);
            if (tx_push && !tx_pop) tx_cnt_q <= tx_cnt_q + CntW'(1);
            else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) rx_mem_q[i] <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else if (rx_flush_q) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            if (rx_push) begin
                rx_mem_q[rx_wptr_q] <= rx_shift_q;
                rx_wptr_q           <= rx_wptr_q + PtrW'(1);
            end
            if (rx_pop) rx_rptr_q <= rx_rptr_q + PtrW'(1);
            if (rx_push && !rx_pop) rx_cnt_q <= rx_cnt_q + CntW'(1);
            else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_q <= StIdle;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            case (tx_state_q)
                StIdle: begin
                    if (tx_pop) begin
                        tx_shift_q <= tx_mem_q[tx_rptr_q];
`ifdef UART_PARITY_EN
                        tx_par_q   <= ^tx_mem_q[tx_rptr_q];
`endif
                        tx_baud_q  <= '0;
                        tx_q       <= 1'b0;
                        tx_state_q <= StStart;
                    end
                end
                StStart: begin
                    if (tx_baud_q == BitLast) begin
                        tx_baud_q  <= '0;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_state_q <= StData;
                    end else tx_baud_q <= tx_baud_q + 16'd1;
                end
                StData: begin
                    if (tx_baud_q == BitLast) begin
                        tx_baud_q <= '0;
                        tx_bit_q  <= tx_bit_q + 3'd1;
                        if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx_q       <= tx_par_q;
                            tx_state_q <= StParity;
`else
                            tx_q       <= 1'b1;
                            tx_state_q <= StStop;
`endif
                        end else begin
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                        end
                    end else tx_baud_q <= tx_baud_q + 16'd1;
                end
                StParity: begin
                    if (tx_baud_q == BitLast) begin
                        tx_baud_q  <= '0;
                        tx_q       <= 1'b1;
                        tx_state_q <= StStop;
                    end else tx_baud_q <= tx_baud_q + 16'd1;
                end
                StStop: begin
                    if (tx_baud_q == BitLast) begin
                        tx_baud_q  <= '0;
                        tx_state_q <= StIdle;
                    end else tx_baud_q <= tx_baud_q + 16'd1;
                end
                default: begin
                    tx_q       <= 1'b1;
                    tx_state_q <= StIdle;
                end
            endcase
        end
    end

    // Synchronizer idles high so reset release never looks like a start edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= StIdle;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
`ifdef UART_PARITY_EN
            rx_par_q   <= 1'b0;
`endif
        end else begin
            rx_s1_q   <= uart_RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            case (rx_state_q)
                StIdle: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_baud_q  <= '0;
                        rx_state_q <= StStart;
                    end
                end
                StStart: begin
                    if (rx_baud_q == HalfBit) begin
                        rx_baud_q  <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s2_q ? StIdle : StData;
                    end else rx_baud_q <= rx_baud_q + 16'd1;
                end
                StData: begin
                    if (rx_baud_q == BitLast) begin
                        rx_baud_q  <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
`ifdef UART_PARITY_EN
                        if (rx_bit_q == 3'd7) rx_state_q <= StParity;
`else
                        if (rx_bit_q == 3'd7) rx_state_q <= StStop;
`endif
                    end else rx_baud_q <= rx_baud_q + 16'd1;
                end
                StParity: begin
                    if (rx_baud_q == BitLast) begin
                        rx_baud_q  <= '0;
`ifdef UART_PARITY_EN
                        rx_par_q   <= rx_s2_q;
`endif
                        rx_state_q <= StStop;
                    end else rx_baud_q <= rx_baud_q + 16'd1;
                end
                StStop: begin
                    if (rx_baud_q == BitLast) begin
                        rx_baud_q  <= '0;
                        rx_state_q <= StIdle;
                    end else rx_baud_q <= rx_baud_q + 16'd1;
                end
                default: rx_state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_uart.sv
// Self-checking bench for axi_lite_uart: directed steps with random payloads,
// a serial-line decoder for TX and a queue model of the RX FIFO and status flags.
module tb_axi_lite_uart;
    localparam int CLK_DIV = 16;
    localparam int DEPTH   = 8;

    logic        clock, reset;
    logic [12:0] s_aw_addr, s_ar_addr;
    logic        s_aw_valid, s_aw_ready, s_w_valid, s_w_ready;
    logic [31:0] s_w_data, s_r_data;
    logic [3:0]  s_w_strb;
    logic [1:0]  s_b_resp, s_r_resp;
    logic        s_b_valid, s_b_ready, s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
    logic        uart_RX, uart_TX, interrupt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_exp[$];
    logic [7:0] mon_bytes[$];
    bit         mon_bad[$];
    bit         m_ovr, m_fe, m_pe, m_ien;

    axi_lite_uart #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(13)) dut (
        .clock(clock), .reset(reset),
        .s_aw_addr(s_aw_addr), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
        .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
        .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
        .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
        .uart_RX(uart_RX), .uart_TX(uart_TX), .interrupt(interrupt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Decodes frames from uart_TX and flags any bit not held for exactly CLK_DIV cycles.
    initial begin : tx_mon
        logic [7:0] v;
        logic       bitv;
        bit         bad;
        forever begin
            @(negedge clock);
            if (uart_TX === 1'b0 && reset === 1'b0) begin
                bad = 0;
                v   = '0;
                for (int i = 0; i < CLK_DIV; i++) begin
                    if (uart_TX !== 1'b0) bad = 1;
                    @(negedge clock);
                end
                for (int b = 0; b < 8; b++) begin
                    bitv = uart_TX;
                    for (int i = 0; i < CLK_DIV; i++) begin
                        if (uart_TX !== bitv) bad = 1;
                        @(negedge clock);
                    end
                    v[b] = bitv;
                end
`ifdef UART_PARITY_EN
                bitv = uart_TX;
                if (bitv !== ^v) bad = 1;
                for (int i = 0; i < CLK_DIV; i++) begin
                    if (uart_TX !== bitv) bad = 1;
                    @(negedge clock);
                end
`endif
                for (int i = 0; i < CLK_DIV; i++) begin
                    if (uart_TX !== 1'b1) bad = 1;
                    @(negedge clock);
                end
                mon_bytes.push_back(v);
                mon_bad.push_back(bad);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input bit txe, input bit txf);
        return {24'h0, m_pe, m_fe, m_ovr, m_ien, txf, txe,
                rx_q.size() == DEPTH, rx_q.size() != 0};
    endfunction

    // Random upper/lower address bits: only addr[3:2] should matter.
    function automatic logic [12:0] mk_addr(input logic [3:0] a);
        logic [12:0] ad;
        ad      = 13'($urandom);
        ad[3:2] = a[3:2];
        return ad;
    endfunction

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit chk);
        int n;
        s_aw_addr  = mk_addr(a);
        s_w_data   = d;
        s_w_strb   = s;
        s_aw_valid = 1'b1;
        s_w_valid  = 1'b1;
        n = 0;
        while (!(s_aw_ready && s_w_ready) && n < 50) begin
            @(posedge clock); #1; n++;
        end
        if (chk) check("wr_ready", {30'h0, s_aw_ready, s_w_ready}, 32'h3);
        @(posedge clock); #1;
        s_aw_valid = 1'b0;
        s_w_valid  = 1'b0;
        if (chk) check("b_valid_early", {31'h0, s_b_valid}, 32'h0);
        n = 0;
        while (!s_b_valid && n < 50) begin
            @(posedge clock); #1; n++;
        end
        check("b_valid", {31'h0, s_b_valid}, 32'h1);
        if (chk) begin
            check("b_latency", 32'(n), 32'd1);
            check("b_resp", {30'h0, s_b_resp}, 32'h0);
        end
        s_b_ready = 1'b1;
        @(posedge clock); #1;
        s_b_ready = 1'b0;
        if (chk) check("ready_back", {30'h0, s_aw_ready, s_w_ready}, 32'h3);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n;
        s_ar_addr  = mk_addr(a);
        s_ar_valid = 1'b1;
        n = 0;
        while (!s_ar_ready && n < 50) begin
            @(posedge clock); #1; n++;
        end
        @(posedge clock); #1;
        s_ar_valid = 1'b0;
        check("r_valid", {31'h0, s_r_valid}, 32'h1);
        d = s_r_data;
        s_r_ready = 1'b1;
        @(posedge clock); #1;
        s_r_ready = 1'b0;
    endtask

    task automatic check_status(input string tag, input bit txe, input bit txf);
        logic [31:0] d;
        axi_read(4'h8, d);
        check(tag, d, exp_status(txe, txf));
        m_ovr = 0;
        m_fe  = 0;
        m_pe  = 0;
    endtask

    task automatic read_rx(input string tag);
        logic [31:0] d, e;
        if (rx_q.size() > 0) e = {24'h0, rx_q.pop_front()};
        else e = 32'h0;
        axi_read(4'h0, d);
        check(tag, d, e);
    endtask

    task automatic wait_bit();
        repeat (CLK_DIV) @(posedge clock);
        #1;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic par, input logic stop);
        uart_RX = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            uart_RX = b[i];
            wait_bit();
        end
`ifdef UART_PARITY_EN
        uart_RX = par;
        wait_bit();
`else
        uart_RX = par & stop & 1'b0;
`endif
        uart_RX = stop;
        wait_bit();
        uart_RX = 1'b1;
        repeat (2) wait_bit();
    endtask

    // Model: bad stop drops the byte with frame_err; a full FIFO drops it with overrun.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        drive_frame(b, ^b, stop);
        if (!stop) m_fe = 1;
        else if (rx_q.size() == DEPTH) m_ovr = 1;
        else rx_q.push_back(b);
    endtask

    task automatic drain_tx(input string tag);
        int n;
        int lim;
        n   = 0;
        lim = tx_exp.size() * 250 + 50;
        while (mon_bytes.size() < tx_exp.size() && n < lim) begin
            @(posedge clock); n++;
        end
        repeat (250) @(posedge clock);
        #1;
        check({tag, "_count"}, 32'(mon_bytes.size()), 32'(tx_exp.size()));
        while (tx_exp.size() > 0 && mon_bytes.size() > 0) begin
            check(tag, {24'h0, mon_bytes.pop_front()}, {24'h0, tx_exp.pop_front()});
            check({tag, "_timing"}, {31'h0, mon_bad.pop_front()}, 32'h0);
        end
        tx_exp.delete();
        mon_bytes.delete();
        mon_bad.delete();
    endtask

    initial begin : stim
        logic [31:0] d;
        logic [7:0]  b;
        reset = 1'b0;
        s_aw_addr = '0; s_aw_valid = 0; s_w_data = '0; s_w_strb = '0; s_w_valid = 0;
        s_b_ready = 0; s_ar_addr = '0; s_ar_valid = 0; s_r_ready = 0;
        uart_RX = 1'b1;
        m_ovr = 0; m_fe = 0; m_pe = 0; m_ien = 0;
        #2 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        check("rst_tx", {31'h0, uart_TX}, 32'h1);
        check("rst_irq", {31'h0, interrupt}, 32'h0);
        check("rst_bvalid", {31'h0, s_b_valid}, 32'h0);
        check("rst_rvalid", {31'h0, s_r_valid}, 32'h0);
        check("rst_rdata", s_r_data, 32'h0);
        check("rst_ready", {29'h0, s_aw_ready, s_w_ready, s_ar_ready}, 32'h7);
        check_status("rst_status", 1, 0);
        check("rst_status_val", exp_status(1, 0), 32'h4);
        axi_read(4'h4, d);
        check("txdata_read", d, 32'h0);
        read_rx("rx_empty_read");

        axi_write(4'h4, 32'h55, 4'h1, 1);
        tx_exp.push_back(8'h55);
        drain_tx("tx55");

        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            axi_write(4'h4, {24'($urandom), b}, 4'hF, 0);
            tx_exp.push_back(b);
        end
        drain_tx("tx_rand");

        // One byte leaves the FIFO immediately, DEPTH more fill it, the last is dropped.
        for (int i = 0; i < DEPTH + 2; i++) begin
            b = 8'($urandom);
            axi_write(4'h4, {24'h0, b}, 4'h1, 0);
            if (i < DEPTH + 1) tx_exp.push_back(b);
        end
        check_status("tx_full_status", 0, 1);
        drain_tx("tx_full");

        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            axi_write(4'h4, {24'h0, b}, 4'h1, 0);
            if (i == 0) tx_exp.push_back(b);
        end
        axi_write(4'hC, 32'h1, 4'h1, 0);
        repeat (2) @(posedge clock);
        #1;
        check_status("tx_flush_status", 1, 0);
        drain_tx("tx_flush");

        send_rx(8'hA3, 1'b1);
        check_status("rx_a3_status", 1, 0);
        read_rx("rx_a3_data");
        check_status("rx_a3_status2", 1, 0);

        for (int i = 0; i < DEPTH + 1; i++) send_rx(8'($urandom), 1'b1);
        check_status("rx_ovr_status", 1, 0);
        for (int i = 0; i < DEPTH; i++) read_rx("rx_ovr_data");
        check_status("rx_ovr_status2", 1, 0);

        send_rx(8'($urandom), 1'b0);
        check_status("frame_err_status", 1, 0);
        check_status("frame_err_status2", 1, 0);

        uart_RX = 1'b0;
        repeat (3) @(posedge clock);
        #1 uart_RX = 1'b1;
        repeat (2) wait_bit();
        check_status("glitch_status", 1, 0);

`ifdef UART_PARITY_EN
        b = 8'($urandom);
        drive_frame(b, ~(^b), 1'b1);
        m_pe = 1;
        check_status("parity_err_status", 1, 0);
        check_status("parity_err_status2", 1, 0);
`endif

        send_rx(8'($urandom), 1'b1);
        send_rx(8'($urandom), 1'b1);
        axi_write(4'hC, 32'h2, 4'h1, 0);
        rx_q.delete();
        repeat (2) @(posedge clock);
        #1;
        check_status("rx_flush_status", 1, 0);

        axi_write(4'hC, 32'h10, 4'h0, 0);
        check("irq_nostrb", {31'h0, interrupt}, 32'h0);
        check_status("nostrb_status", 1, 0);
        axi_write(4'hC, 32'h10, 4'h1, 0);
        m_ien = 1;
        check("irq_on", {31'h0, interrupt}, 32'h1);
        check_status("ien_status", 1, 0);
        axi_write(4'hC, 32'h0, 4'h1, 0);
        m_ien = 0;
        check("irq_off", {31'h0, interrupt}, 32'h0);

        axi_write(4'h4, 32'hF0, 4'h1, 0);
        repeat (CLK_DIV + 4) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("rst_mid_tx", {31'h0, uart_TX}, 32'h1);
        check("rst_mid_irq", {31'h0, interrupt}, 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        rx_q.delete();
        m_ovr = 0; m_fe = 0; m_pe = 0; m_ien = 0;
        check_status("rst_mid_status", 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
